dpram_be: RTL and testbench

DPRAM_BE -- requirements
Module: dpram_be

---
 rtl/dpram_pkg.sv | 13 +
 rtl/dpram_be_oreg.sv | 43 ++++
 rtl/dpram_be.sv | 116 +++++++++++
 tb/tb_dpram_be.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared definitions for the byte-enable dual-port RAM.
// Covers the clear/ready state encoding and the write-priority selectors.
package dpram_pkg;

  typedef enum logic {
    CLR = 1'b0,
    RDY = 1'b1
  } state_e;

  localparam int WP_P1 = 1;
  localparam int WP_P2 = 2;

endpackage

// File: rtl/dpram_be_oreg.sv
// Per-port read-data pipeline. With lat=1 there is one capture register.
// With lat=2 a second register follows the first and loads only on accepted accesses.
module dpram_be_oreg #(
  parameter int m   = 16,
  parameter int lat = 1
) (
  input  logic         ck_i,
  input  logic         rn_i,
  input  logic         en_i,
  input  logic [m-1:0] d_i,
  output logic [m-1:0] q_o
);

  logic [m-1:0] s1_q;

  always_ff @(posedge ck_i or negedge rn_i) begin
    if (!rn_i)     s1_q <= '0;
    else if (en_i) s1_q <= d_i;
  end

  generate
    if (lat == 1) begin : g_lat1
      assign q_o = s1_q;
    end else begin : g_lat2
      logic [m-1:0] s2_q;
      logic         v_q;

      // The second stage copies stage 1 only when stage 1 was just loaded.
      always_ff @(posedge ck_i or negedge rn_i) begin
        if (!rn_i) begin
          s2_q <= '0;
          v_q  <= 1'b0;
        end else begin
          v_q <= en_i;
          if (v_q) s2_q <= s1_q;
        end
      end

      assign q_o = s2_q;
    end
  endgenerate

endmodule

// File: rtl/dpram_be.sv
// True dual-port RAM with byte-lane write enables and read-old behaviour.
// After reset, and on request, the whole array is zeroed by a walking clear pass.
module dpram_be
  import dpram_pkg::*;
#(
  parameter int n   = 8,
  parameter int nb  = 2,
  parameter int lat = 1,
  parameter int wp  = 1
) (
  input  logic          ck,
  input  logic          rn,
  input  logic          clr,
  output logic          busy,
  input  logic          ce1,
  input  logic          we1,
  input  logic [nb-1:0] be1,
  input  logic [n-1:0]  ad1,
  input  logic [8*nb-1:0] di1,
  output logic [8*nb-1:0] dq1,
  input  logic          ce2,
  input  logic          we2,
  input  logic [nb-1:0] be2,
  input  logic [n-1:0]  ad2,
  input  logic [8*nb-1:0] di2,
  output logic [8*nb-1:0] dq2,
  output logic          col
);

  localparam int m     = 8 * nb;
  localparam int depth = 2 ** n;
  localparam logic [n-1:0] CNT_ONE  = 1;
  localparam logic [n-1:0] CNT_LAST = '1;

  generate
    if (!(lat == 1 || lat == 2)) begin : g_bad_lat
      $error("dpram_be: lat must be 1 or 2");
    end
    if (!(wp == WP_P1 || wp == WP_P2)) begin : g_bad_wp
      $error("dpram_be: wp must be 1 or 2");
    end
  endgenerate

  state_e         state_q, state_d;
  logic [n-1:0]   cnt_q, cnt_d;
  logic           col_q, col_d;
  logic           acc1, acc2, wr1, wr2;
  logic [nb-1:0]  ovl;
  logic [m-1:0]   mem [0:depth-1];

  assign busy = (state_q == CLR);
  assign acc1 = ce1 && !busy;
  assign acc2 = ce2 && !busy;
  assign wr1  = acc1 && we1;
  assign wr2  = acc2 && we2;
  assign ovl  = (wr1 && wr2 && (ad1 == ad2)) ? (be1 & be2) : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = |ovl;
    case (state_q)
      CLR: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = RDY;
      end
      RDY: begin
        if (clr) state_d = CLR;
      end
      default: state_d = CLR;
    endcase
  end

  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      state_q <= CLR;
      cnt_q   <= '0;
      col_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
    end
  end

  // On an overlapping lane only the priority port writes; other lanes write independently.
  always_ff @(posedge ck) begin
    if (state_q == CLR) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < nb; i++) begin
        if (wr1 && be1[i] && !(ovl[i] && wp == WP_P2)) mem[ad1][8*i +: 8] <= di1[8*i +: 8];
        if (wr2 && be2[i] && !(ovl[i] && wp == WP_P1)) mem[ad2][8*i +: 8] <= di2[8*i +: 8];
      end
    end
  end

  assign col = col_q;

  dpram_be_oreg #(.m(m), .lat(lat)) u_oreg1 (
    .ck_i (ck),
    .rn_i (rn),
    .en_i (acc1),
    .d_i  (mem[ad1]),
    .q_o  (dq1)
  );

  dpram_be_oreg #(.m(m), .lat(lat)) u_oreg2 (
    .ck_i (ck),
    .rn_i (rn),
    .en_i (acc2),
    .d_i  (mem[ad2]),
    .q_o  (dq2)
  );

endmodule

// File: tb/tb_dpram_be.sv
// Directed bench for dpram_be: two instances share stimulus, A with lat=1/wp=1 and B with lat=2/wp=2.
module tb_dpram_be;

  logic        ck = 1'b0;
  logic        rn = 1'b0;
  logic        clr = 1'b0;
  logic        ce1 = 1'b0, we1 = 1'b0, ce2 = 1'b0, we2 = 1'b0;
  logic [1:0]  be1 = '0, be2 = '0;
  logic [3:0]  ad1 = '0, ad2 = '0;
  logic [15:0] di1 = '0, di2 = '0;
  logic        busyA, busyB, colA, colB;
  logic [15:0] dqA1, dqA2, dqB1, dqB2;
  int          checks = 0;
  int          failures = 0;

  always #5 ck = ~ck;

  dpram_be #(.n(4), .nb(2), .lat(1), .wp(1)) dutA (
    .ck(ck), .rn(rn), .clr(clr), .busy(busyA),
    .ce1(ce1), .we1(we1), .be1(be1), .ad1(ad1), .di1(di1), .dq1(dqA1),
    .ce2(ce2), .we2(we2), .be2(be2), .ad2(ad2), .di2(di2), .dq2(dqA2),
    .col(colA)
  );

  dpram_be #(.n(4), .nb(2), .lat(2), .wp(2)) dutB (
    .ck(ck), .rn(rn), .clr(clr), .busy(busyB),
    .ce1(ce1), .we1(we1), .be1(be1), .ad1(ad1), .di1(di1), .dq1(dqB1),
    .ce2(ce2), .we2(we2), .be2(be2), .ad2(ad2), .di2(di2), .dq2(dqB2),
    .col(colB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic applyStimulus(input logic c1, input logic w1, input logic [1:0] b1,
                               input logic [3:0] a1, input logic [15:0] d1,
                               input logic c2, input logic w2, input logic [1:0] b2,
                               input logic [3:0] a2, input logic [15:0] d2);
    ce1 = c1; we1 = w1; be1 = b1; ad1 = a1; di1 = d1;
    ce2 = c2; we2 = w2; be2 = b2; ad2 = a2; di2 = d2;
    tick();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 2'b00, 4'd0, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
  endtask

  task automatic waitClear(input string tag);
    int cyc = 0;
    while (busyA && cyc < 100) begin
      tick();
      cyc++;
    end
    checkOutput(tag, cyc, 16);
    checkOutput({tag, "_busyB"}, busyB, 0);
  endtask

  task automatic readAllZero(input string tag);
    for (int a = 0; a < 16; a++) begin
      applyStimulus(1, 0, 2'b00, a[3:0], 16'h0, 1, 0, 2'b00, a[3:0], 16'h0);
      checkOutput($sformatf("%s_a%0d", tag, a), dqA1, 16'h0000);
      checkOutput($sformatf("%s_p2_a%0d", tag, a), dqA2, 16'h0000);
    end
    idle();
  endtask

  initial begin
    tick();
    checkOutput("rst_busy", busyA, 1);
    checkOutput("rst_dq1", dqA1, 16'h0000);
    checkOutput("rst_dqB2", dqB2, 16'h0000);
    checkOutput("rst_col", colA, 0);
    tick();
    rn = 1'b1;
    waitClear("init_clear_cycles");
    readAllZero("init_zero");

    // Byte-lane write over existing data; lat=2 lags by one edge.
    applyStimulus(1, 1, 2'b11, 4'd3, 16'h1234, 0, 0, 2'b00, 4'd0, 16'h0);
    applyStimulus(1, 1, 2'b01, 4'd3, 16'hA55A, 0, 0, 2'b00, 4'd0, 16'h0);
    checkOutput("own_write_old", dqA1, 16'h1234);
    applyStimulus(1, 0, 2'b00, 4'd3, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
    checkOutput("be_read_lat1", dqA1, 16'h125A);
    checkOutput("be_read_lat2_early", dqB1, 16'h1234);
    idle();
    checkOutput("be_read_lat2", dqB1, 16'h125A);
    checkOutput("lat1_hold", dqA1, 16'h125A);

    // Full-overlap collision at address 5.
    applyStimulus(1, 1, 2'b11, 4'd5, 16'h1111, 1, 1, 2'b11, 4'd5, 16'h2222);
    checkOutput("col_A", colA, 1);
    checkOutput("col_B", colB, 1);
    idle();
    checkOutput("col_A_drop", colA, 0);
    applyStimulus(1, 0, 2'b00, 4'd5, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
    checkOutput("col_wp1_data", dqA1, 16'h1111);
    idle();
    checkOutput("col_wp2_data", dqB1, 16'h2222);

    // Partial-overlap collision at address 8.
    applyStimulus(1, 1, 2'b11, 4'd8, 16'h1111, 1, 1, 2'b01, 4'd8, 16'h2222);
    checkOutput("pcol_A", colA, 1);
    applyStimulus(1, 0, 2'b00, 4'd8, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
    checkOutput("pcol_wp1_data", dqA1, 16'h1111);
    idle();
    checkOutput("pcol_wp2_data", dqB1, 16'h1122);

    // Same address, disjoint lanes: no collision, both lanes land.
    applyStimulus(1, 1, 2'b01, 4'd6, 16'hAAAA, 1, 1, 2'b10, 4'd6, 16'hBBBB);
    checkOutput("ncol_A", colA, 0);
    applyStimulus(1, 0, 2'b00, 4'd6, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
    checkOutput("ncol_data", dqA1, 16'hBBAA);

    // Write on port 1 while port 2 reads the same word.
    applyStimulus(1, 1, 2'b11, 4'd7, 16'hBEEF, 1, 0, 2'b00, 4'd7, 16'h0);
    checkOutput("rw_old_dq2", dqA2, 16'h0000);
    checkOutput("rw_nocol", colA, 0);
    applyStimulus(0, 0, 2'b00, 4'd0, 16'h0, 1, 0, 2'b00, 4'd7, 16'h0);
    checkOutput("rw_new_dq2", dqA2, 16'hBEEF);

    // clr together with an access, then writes ignored while busy.
    applyStimulus(1, 1, 2'b11, 4'd9, 16'hCAFE, 0, 0, 2'b00, 4'd0, 16'h0);
    clr = 1'b1;
    applyStimulus(1, 0, 2'b00, 4'd9, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
    clr = 1'b0;
    checkOutput("clr_access_done", dqA1, 16'hCAFE);
    checkOutput("clr_busy", busyA, 1);
    applyStimulus(1, 1, 2'b11, 4'd9, 16'hFFFF, 1, 1, 2'b11, 4'd9, 16'h0F0F);
    checkOutput("busy_dq1_hold", dqA1, 16'hCAFE);
    checkOutput("busy_nocol", colA, 0);
    for (int i = 0; i < 4; i++) idle();

    // Reset in the middle of the clear pass.
    rn = 1'b0;
    #1;
    checkOutput("midrst_busy", busyA, 1);
    checkOutput("midrst_dqA1", dqA1, 16'h0000);
    checkOutput("midrst_dqB1", dqB1, 16'h0000);
    rn = 1'b1;
    waitClear("restart_clear_cycles");
    readAllZero("post_clear_zero");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
